xgmii_frame_gen: RTL

- Parametrised, synthesisable XGMII 64-bit Ethernet frame generator; successor to the fixed traffic setup used in the measure system bench.
- Emits back-to-back or gapped frames with programmable length, gap, count and headers, carrying a sequence number.
- Drives one MAC's xgmii_N_txd/txc directly.
- Used as the stimulus source for measure throughput/latency runs, both in simulation and on the KC705 board.

---
 rtl/xgmii_frame_gen.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/xgmii_frame_gen.sv
// XGMII 64-bit Ethernet frame generator: programmable length, gap, count and headers, sequence-numbered frames.
// Optional macro XGMII_GEN_FCS_EN replaces the zero FCS with a real CRC-32; without it no CRC logic is built.
//
// state | meaning
// IDLE  | idle words; wait for tx_enable (re-armed only after it has been low)
// START | start word 0xFB + preamble/SFD
// DATA  | header, sequence number, payload, FCS; short last word carries 0xFD
// TERM  | stand-alone terminate word when the frame length is a multiple of 8
// GAP   | inter_frame_gap idle words
module xgmii_frame_gen #(
    parameter int MIN_FRAME_LEN = 64,
    parameter int MAX_FRAME_LEN = 1518,
    parameter int COUNT_W       = 32,
    parameter int PAYLOAD_MODE  = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               tx_enable,
    input  logic [15:0]        frame_len,
    input  logic [31:0]        inter_frame_gap,
    input  logic [COUNT_W-1:0] frame_count,
    input  logic [47:0]        dst_mac,
    input  logic [47:0]        src_mac,
    input  logic [15:0]        ethertype,
    output logic [63:0]        xgmii_txd,
    output logic [7:0]         xgmii_txc,
    output logic               busy,
    output logic [COUNT_W-1:0] tx_frames,
    output logic               tx_done
);
    localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
    localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
    localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;
    localparam logic [15:0] LEN_MIN    = 16'(MIN_FRAME_LEN);
    localparam logic [15:0] LEN_MAX    = 16'(MAX_FRAME_LEN);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_GAP} state_t;
    state_t state, state_nxt, after_term;

    logic [15:0]        len_q, rem_q, len_clamped, base, type_q;
    logic [31:0]        gap_q, gap_cnt, seq_q;
    logic [COUNT_W-1:0] fc_q, run_cnt, tx_frames_q;
    logic [47:0]        dst_q, src_q;
    logic [143:0]       hdr;
    logic               lock_q, last_word, term_evt, run_end, tx_done_q;
    logic [2:0]         tail;
    logic [63:0]        data_raw, data_word, txd_nxt, txd_q;
    logic [7:0]         txc_nxt, txc_q;

    assign len_clamped = (frame_len < LEN_MIN) ? LEN_MIN :
                         (frame_len > LEN_MAX) ? LEN_MAX : frame_len;
    // rem_q counts the bytes still to send in this frame, down to the last word
    assign last_word  = rem_q <= 16'd8;
    assign tail       = rem_q[2:0];
    assign term_evt   = (state == S_DATA && last_word && tail != 3'd0) || state == S_TERM;
    assign run_end    = term_evt && fc_q != '0 && (run_cnt + COUNT_W'(1)) == fc_q;
    assign after_term = run_end ? S_IDLE :
                        (gap_q != 32'd0) ? S_GAP :
                        (tx_enable ? S_START : S_IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tx_enable && !lock_q) state_nxt = S_START;
            S_START: state_nxt = S_DATA;
            S_DATA:  if (last_word) state_nxt = (tail == 3'd0) ? S_TERM : after_term;
            S_TERM:  state_nxt = after_term;
            S_GAP:   if (gap_cnt == 32'd1) state_nxt = tx_enable ? S_START : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            len_q       <= LEN_MIN;
            gap_q       <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            type_q      <= '0;
            fc_q        <= '0;
            run_cnt     <= '0;
            rem_q       <= '0;
            gap_cnt     <= '0;
            seq_q       <= '0;
            tx_frames_q <= '0;
            lock_q      <= 1'b0;
        end else begin
            if (state_nxt == S_START) begin
                len_q  <= len_clamped;
                gap_q  <= inter_frame_gap;
                dst_q  <= dst_mac;
                src_q  <= src_mac;
                type_q <= ethertype;
            end
            if (state == S_IDLE && state_nxt == S_START) begin
                fc_q    <= frame_count;
                run_cnt <= '0;
            end else if (term_evt) begin
                run_cnt <= run_cnt + COUNT_W'(1);
            end
            if (state == S_START)     rem_q <= len_q;
            else if (state == S_DATA) rem_q <= rem_q - 16'd8;
            if (term_evt) begin
                seq_q       <= seq_q + 32'd1;
                tx_frames_q <= tx_frames_q + COUNT_W'(1);
                gap_cnt     <= gap_q;
            end else if (state == S_GAP) begin
                gap_cnt <= gap_cnt - 32'd1;
            end
            if (run_end)         lock_q <= 1'b1;
            else if (!tx_enable) lock_q <= 1'b0;
        end
    end

    assign base = len_q - rem_q;
    assign hdr  = {dst_q, src_q, type_q, seq_q};

    always_comb begin
        logic [15:0] b;
        data_raw = '0;
        for (int i = 0; i < 8; i++) begin
            b = base + 16'(i);
            if (b < 16'd18)
                data_raw[8*i +: 8] = 8'(hdr >> (8'd136 - {b[4:0], 3'b000}));
            else if (b < len_q - 16'd4)
                data_raw[8*i +: 8] = (PAYLOAD_MODE == 0) ? 8'(b - 16'd18) : 8'h00;
        end
    end

`ifdef XGMII_GEN_FCS_EN
    logic [31:0] crc_q, crc_word, fcs;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int n = 0; n < 8; n++)
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        return x;
    endfunction

    // FCS lanes may share a word with the last data bytes, so they use the updated CRC
    always_comb begin
        logic [15:0] b;
        logic [1:0]  j;
        crc_word  = crc_q;
        data_word = data_raw;
        for (int i = 0; i < 8; i++) begin
            b = base + 16'(i);
            if (state == S_DATA && b < len_q - 16'd4)
                crc_word = crc32_byte(crc_word, data_raw[8*i +: 8]);
        end
        fcs = ~crc_word;
        for (int i = 0; i < 8; i++) begin
            b = base + 16'(i);
            j = 2'(b - (len_q - 16'd4));
            if (b >= len_q - 16'd4 && b < len_q)
                data_word[8*i +: 8] = 8'(fcs >> {j, 3'b000});
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)             crc_q <= 32'hFFFFFFFF;
        else if (state == S_START) crc_q <= 32'hFFFFFFFF;
        else if (state == S_DATA)  crc_q <= crc_word;
    end
`else
    assign data_word = data_raw;
`endif

    always_comb begin
        txd_nxt = IDLE_WORD;
        txc_nxt = 8'hFF;
        case (state)
            S_START: begin
                txd_nxt = START_WORD;
                txc_nxt = 8'h01;
            end
            S_DATA: begin
                txd_nxt = data_word;
                txc_nxt = 8'h00;
                if (last_word && tail != 3'd0) begin
                    for (int i = 0; i < 8; i++) begin
                        if (3'(i) == tail)     txd_nxt[8*i +: 8] = 8'hFD;
                        else if (3'(i) > tail) txd_nxt[8*i +: 8] = 8'h07;
                    end
                    txc_nxt = 8'hFF << tail;
                end
            end
            S_TERM: begin
                txd_nxt = TERM_WORD;
                txc_nxt = 8'hFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            txd_q     <= IDLE_WORD;
            txc_q     <= 8'hFF;
            tx_done_q <= 1'b0;
        end else begin
            txd_q     <= txd_nxt;
            txc_q     <= txc_nxt;
            tx_done_q <= run_end;
        end
    end

    assign xgmii_txd = txd_q;
    assign xgmii_txc = txc_q;
    assign tx_done   = tx_done_q;
    assign tx_frames = tx_frames_q;
    assign busy      = (state != S_IDLE);

endmodule
